// File: rtl/text_pkg.sv
// Shared constants, control codes and state encoding for the text console controller.
// Screen geometry is 80x50 cells stored row-major in a 12-bit addressed text RAM.
package text_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 50;
    localparam int AW    = 12;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] FILL  = 8'h20;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [6:0]    COL_LAST      = 7'(COLS - 1);
    localparam logic [5:0]    ROW_LAST      = 6'(ROWS - 1);
    localparam logic [AW-1:0] ROW_STRIDE    = AW'(COLS);
    localparam logic [AW-1:0] CELL_COUNT    = AW'(CELLS);
    localparam logic [AW-1:0] CELL_LAST     = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLS);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_SCR_RD,
        ST_SCR_WR,
        ST_SCR_FILL
    } state_t;

    // row*80 built from shifts so no multiplier is inferred.
    function automatic logic [AW-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        logic [AW-1:0] r;
        r = AW'(row);
        return (r << 6) + (r << 4) + AW'(col);
    endfunction

endpackage

// File: rtl/text_fill.sv
// Linear fill engine: emits one consecutive address per cycle for a given count.
// Comes out of reset already running a full-screen clear.
module text_fill
    import text_pkg::*;
(
    input  logic          clk,
    input  logic          srst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] count,
    output logic          wr,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] addr_reg;
    logic [AW-1:0] remain_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            addr_reg   <= '0;
            remain_reg <= CELL_COUNT;
        end else if (start) begin
            addr_reg   <= start_addr + AW'(1);
            remain_reg <= count - AW'(1);
        end else if (remain_reg != '0) begin
            addr_reg   <= addr_reg + AW'(1);
            remain_reg <= remain_reg - AW'(1);
        end
    end

    // The start cycle already emits start_addr, so the caller's first write follows start by one cycle.
    assign wr   = start || (remain_reg != '0);
    assign addr = start ? start_addr : addr_reg;

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style byte sink for the 80x50 text RAM: cursor tracking, control codes,
// clear-screen and scroll-up through RAM port B while scanout owns port A.
module text_console_ctrl
    import text_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic [6:0]    cur_col,
    output logic [5:0]    cur_row,
    output logic          busy
);

    state_t        state_reg;
    logic [6:0]    col_reg;
    logic [5:0]    row_reg;
    logic [AW-1:0] src_reg;
    logic          in_ready_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [7:0]    wdata_reg;
    logic          mem_we_reg;
    logic          copy_wr_reg;
    logic          busy_reg;

    logic          accept;
    logic          at_last_row;
    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW-1:0] fill_len;
    logic          fill_wr;
    logic [AW-1:0] fill_addr;

    assign accept      = (state_reg == ST_IDLE) && in_ready_reg && in_valid;
    assign at_last_row = (row_reg == ROW_LAST);

    always_comb begin
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = CELL_COUNT;
        if (accept && in_data == CH_FF) begin
            fill_start = 1'b1;
        end else if (state_reg == ST_SCR_WR && src_reg == CELL_LAST) begin
            fill_start = 1'b1;
            fill_base  = LAST_ROW_BASE;
            fill_len   = ROW_STRIDE;
        end
    end

    text_fill u_fill (
        .clk        (clk),
        .srst       (rst),
        .start      (fill_start),
        .start_addr (fill_base),
        .count      (fill_len),
        .wr         (fill_wr),
        .addr       (fill_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_CLEAR;
            col_reg      <= '0;
            row_reg      <= '0;
            src_reg      <= '0;
            in_ready_reg <= 1'b0;
            mem_addr_reg <= '0;
            wdata_reg    <= FILL;
            mem_we_reg   <= 1'b0;
            copy_wr_reg  <= 1'b0;
            busy_reg     <= 1'b1;
        end else begin
            copy_wr_reg <= 1'b0;
            case (state_reg)
                ST_CLEAR, ST_SCR_FILL: begin
                    if (!fill_wr) begin
                        mem_we_reg   <= 1'b0;
                        state_reg    <= ST_IDLE;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                        if (state_reg == ST_CLEAR) begin
                            col_reg <= '0;
                            row_reg <= '0;
                        end
                    end
                end
                ST_IDLE: begin
                    mem_we_reg <= 1'b0;
                    if (!in_ready_reg) begin
                        in_ready_reg <= 1'b1;
                    end else if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (in_data >= 8'h20) begin
                            state_reg    <= ST_PUT;
                            mem_we_reg   <= 1'b1;
                            mem_addr_reg <= cell_addr(row_reg, col_reg);
                            wdata_reg    <= in_data;
                        end else begin
                            case (in_data)
                                CH_CR: col_reg <= '0;
                                CH_LF: begin
                                    col_reg <= '0;
                                    if (!at_last_row) begin
                                        row_reg <= row_reg + 6'd1;
                                    end else begin
                                        state_reg    <= ST_SCR_RD;
                                        src_reg      <= ROW_STRIDE;
                                        mem_addr_reg <= ROW_STRIDE;
                                        busy_reg     <= 1'b1;
                                    end
                                end
                                CH_BS: begin
                                    if (col_reg != '0) col_reg <= col_reg - 7'd1;
                                end
                                CH_FF: begin
                                    state_reg <= ST_CLEAR;
                                    busy_reg  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_PUT: begin
                    mem_we_reg <= 1'b0;
                    if (col_reg != COL_LAST) begin
                        col_reg      <= col_reg + 7'd1;
                        state_reg    <= ST_IDLE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        col_reg <= '0;
                        if (!at_last_row) begin
                            row_reg      <= row_reg + 6'd1;
                            state_reg    <= ST_IDLE;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_SCR_RD;
                            src_reg      <= ROW_STRIDE;
                            mem_addr_reg <= ROW_STRIDE;
                            busy_reg     <= 1'b1;
                        end
                    end
                end
                ST_SCR_RD: begin
                    state_reg    <= ST_SCR_WR;
                    mem_addr_reg <= src_reg - ROW_STRIDE;
                    mem_we_reg   <= 1'b1;
                    copy_wr_reg  <= 1'b1;
                end
                ST_SCR_WR: begin
                    mem_we_reg <= 1'b0;
                    if (src_reg == CELL_LAST) begin
                        state_reg <= ST_SCR_FILL;
                    end else begin
                        src_reg      <= src_reg + AW'(1);
                        mem_addr_reg <= src_reg + AW'(1);
                        state_reg    <= ST_SCR_RD;
                    end
                end
                default: begin
                    state_reg    <= ST_CLEAR;
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b1;
                end
            endcase
            // Fill engine owns port B whenever it is emitting, including its start cycle.
            if (fill_wr) begin
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= fill_addr;
                wdata_reg    <= FILL;
            end
        end
    end

    // Copy writes forward the RAM's own registered read data, keeping the copy at two cycles per cell.
    assign mem_wdata = copy_wr_reg ? mem_rdata : wdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_we    = mem_we_reg;
    assign in_ready  = in_ready_reg;
    assign cur_col   = col_reg;
    assign cur_row   = row_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a behavioural port-B RAM (1-cycle registered read).
module tb_text_console_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [6:0]  cur_col;
    logic [5:0]  cur_row;
    logic        busy;

    logic [7:0]  ram [0:4095];
    int          checks = 0;
    int          errors = 0;

    text_console_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds in_valid until the DUT accepts; returns on the sample just after the accept edge.
    task automatic send(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 20000), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        $display("TXN byte=%02h waited=%0d we=%0d addr=%0d wdata=%02h", b, n, mem_we, mem_addr, mem_wdata);
    endtask

    // Expects 4000 consecutive FILL writes starting at the current sample.
    task automatic clear_check(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 4000; i++) begin
            if (mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_wdata !== 8'h20 ||
                busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        check(tag, 32'(bad), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cursor"}, {19'd0, cur_row, cur_col}, 32'd0);
    endtask

    task automatic ram_check(input string tag, input int lo, input int hi, input logic [7:0] val);
        int bad;
        bad = 0;
        for (int i = lo; i <= hi; i++) if (ram[i] !== val) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_cursor", {19'd0, cur_row, cur_col}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        clear_check("por_clear");
        ram_check("por_ram", 0, 3999, 8'h20);

        send(8'h41);
        check("a_we", 32'(mem_we), 32'd1);
        check("a_addr", 32'(mem_addr), 32'd0);
        check("a_wdata", 32'(mem_wdata), 32'h41);
        check("a_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("a_ready_high", 32'(in_ready), 32'd1);
        check("a_col", 32'(cur_col), 32'd1);
        check("a_we_off", 32'(mem_we), 32'd0);

        send(8'h0D);
        check("cr_col", 32'(cur_col), 32'd0);
        check("cr_we", 32'(mem_we), 32'd0);

        for (int i = 0; i < 80; i++) begin
            send(8'(8'h30 + i));
            if (i == 79) begin
                check("row0_last_addr", 32'(mem_addr), 32'd79);
                check("row0_last_data", 32'(mem_wdata), 32'h7F);
            end
        end
        @(negedge clk);
        check("wrap_cursor", {19'd0, cur_row, cur_col}, {19'd0, 6'd1, 7'd0});
        bad = 0;
        for (int i = 0; i < 80; i++) if (ram[i] !== 8'(8'h30 + i)) bad++;
        check("row0_ram", 32'(bad), 32'd0);
        send(8'h42);
        check("byte81_addr", 32'(mem_addr), 32'd80);
        check("byte81_data", 32'(mem_wdata), 32'h42);

        send(8'h0C);
        clear_check("ff_clear");

        for (int i = 0; i < 80; i++) send(8'h58);
        for (int i = 0; i < 80; i++) send(8'h59);
        @(negedge clk);
        check("xy_cursor", {19'd0, cur_row, cur_col}, {19'd0, 6'd2, 7'd0});
        for (int i = 0; i < 47; i++) send(8'h0A);
        @(negedge clk);
        check("lf_cursor", {19'd0, cur_row, cur_col}, {19'd0, 6'd49, 7'd0});

        send(8'h08);
        check("bs0_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("bs0_cursor", {19'd0, cur_row, cur_col}, {19'd0, 6'd49, 7'd0});
        send(8'h07);
        check("bel_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("bel_cursor", {19'd0, cur_row, cur_col}, {19'd0, 6'd49, 7'd0});

        send(8'h0A);
        n = 0;
        while (busy === 1'b1 && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check("scroll_busy_cycles", 32'(n), 32'd7920);
        check("scroll_ready", 32'(in_ready), 32'd1);
        check("scroll_cursor", {19'd0, cur_row, cur_col}, {19'd0, 6'd49, 7'd0});
        ram_check("scroll_row0", 0, 79, 8'h59);
        ram_check("scroll_rest", 80, 3999, 8'h20);

        // Second scroll with the next byte held valid throughout
        send(8'h0A);
        send(8'h51);
        check("held_addr", 32'(mem_addr), 32'd3920);
        check("held_data", 32'(mem_wdata), 32'h51);
        @(negedge clk);
        check("held_col", 32'(cur_col), 32'd1);
        send(8'h08);
        check("bs1_col", 32'(cur_col), 32'd0);
        check("bs1_we", 32'(mem_we), 32'd0);

        send(8'h0A);
        repeat (1000) @(negedge clk);
        check("mid_scroll_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_cursor", {19'd0, cur_row, cur_col}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        clear_check("mid_rst_clear");
        ram_check("mid_rst_ram", 0, 3999, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
